control_pipeline: RTL and testbench
===================================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter OP_ALU_BUS_SIZE, default 2, the ALU-op field width.
REQ-002 SHALL have parameter RETIRE_CNT_SIZE, default 16, the retire-counter width.
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  ID holds a real instruction this cycle
- i_halt  in  1  freeze the whole pipeline
- i_bubble  in  1  load-use hazard: insert a bubble into ID/EX
- i_flush  in  1  taken branch: kill ID/EX and EX/MEM contents
- i_wb_reg_write, i_wb_mem_to_reg, i_mem_branch, i_mem_read, i_mem_write, i_ex_dest, i_ex_alu_src  in  1 each  decoded controls from ID
- i_ex_alu_op  in  OP_ALU_BUS_SIZE  decoded ALU op
- o_ex_valid, o_ex_dest, o_ex_alu_src  out  1 each  ID/EX stage controls
- o_ex_alu_op  out  OP_ALU_BUS_SIZE  ID/EX ALU op
- o_mem_valid, o_mem_branch, o_mem_read, o_mem_write  out  1 each  EX/MEM stage controls
- o_wb_valid, o_wb_reg_write, o_wb_mem_to_reg  out  1 each  MEM/WB stage controls
- o_inflight  out  2  count of valid stages, 0..3
- o_drained  out  1  high when o_inflight == 0
- o_retired  out  RETIRE_CNT_SIZE  count of instructions that left MEM/WB

Function
REQ-004 SHALL hold three stage registers:
- ID/EX: valid, EX, MEM and WB fields
- EX/MEM: valid, MEM and WB fields
- MEM/WB: valid, WB fields
REQ-005 A bubble SHALL be: valid=0, every 1-bit control 0, ALU op all zeros.
REQ-006 Each rising edge SHALL apply one rule, in this priority order:
- i_halt=1: all registers and o_retired hold
- i_flush=1: ID/EX <= bubble; EX/MEM <= bubble; MEM/WB <= EX/MEM
- i_bubble=1 or i_valid=0: ID/EX <= bubble; EX/MEM <= ID/EX; MEM/WB <= EX/MEM
- otherwise: ID/EX <= inputs with valid=1; EX/MEM <= ID/EX; MEM/WB <= EX/MEM
REQ-007 i_flush together with i_bubble SHALL behave as flush alone.
REQ-008 When i_valid=1 and no hazard applies, X/undefined values on i_ex_dest or i_wb_mem_to_reg SHALL be captured as 0.
REQ-009 Latency: inputs SHALL appear on ID/EX outputs 1 cycle later, EX/MEM 2 cycles later, MEM/WB 3 cycles later (with no halt cycles in between).
REQ-010 All stage outputs SHALL be driven directly from registers, with no combinational path from inputs.
REQ-011 o_inflight SHALL be the combinational sum of o_ex_valid, o_mem_valid and o_wb_valid.
REQ-012 o_retired SHALL increment by 1 on each non-halted edge where o_wb_valid=1, and SHALL wrap from all-ones to 0.

Reset
REQ-013 Asserting i_reset SHALL immediately force all three stages to bubble and o_retired to 0, whatever the clock is doing.
REQ-014 While i_reset is high, the block SHALL ignore all other inputs.
REQ-015 Reset asserted mid-operation SHALL discard in-flight instructions without counting them as retired.
REQ-016 After reset, o_inflight SHALL be 0 and o_drained SHALL be 1.

Structure
REQ-017 A shared header SHALL define:
- the default OP_ALU_BUS_SIZE
- the bubble ALU-op constant
- the HIGH/LOW constants used by the main decoder
REQ-018 There SHALL be one sub-module, ctrl_stage_reg: a parameterised-width register with hold, clear-to-bubble and async reset, instantiated three times.

Verification
REQ-019 Straight flow: after reset, drive a LW pattern (reg_write=1, mem_to_reg=0, mem_read=1, alu_src=0, alu_op=00, dest=0) for one cycle. Required: o_ex_valid=1 at +1 cycle, o_mem_read=1 at +2, o_wb_reg_write=1 at +3, o_retired=1 at +4.
REQ-020 Flush: send R-type then BEQ back to back, assert i_flush when the BEQ is in EX/MEM. Required: EX/MEM and ID/EX become bubbles, the R-type still retires, o_retired=1.
REQ-021 Bubble plus halt: assert i_bubble for one cycle, then i_halt for 3 cycles. Required: one invalid slot between instructions, all outputs unchanged during halt, o_inflight constant during halt.
REQ-022 Wrap: with RETIRE_CNT_SIZE=2, retire 5 valid instructions. Required: o_retired sequence 1, 2, 3, 0, 1.
REQ-023 Async reset: assert i_reset between clock edges with o_inflight=3. Required: outputs clear before the next edge, o_retired=0, o_drained=1.
REQ-024 Simultaneous: i_flush=1, i_bubble=1, i_valid=1 in the same cycle. Required: identical result to flush alone (REQ-006).

Source files
------------

// File: rtl/control_pipeline_pkg.sv
// Shared constants and step selection for the ID/EX -> EX/MEM -> MEM/WB control pipeline.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package control_pipeline_pkg;

    localparam int OP_ALU_BUS_SIZE_DEF = 2;

    // Decoder-level logic constants
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // ALU op carried by a bubble
    localparam logic [OP_ALU_BUS_SIZE_DEF-1:0] ALU_OP_BUBBLE = '0;

    // What the pipeline does on a given edge
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_FLUSH,
        STEP_BUBBLE,
        STEP_LOAD
    } step_e;

    // Halt beats flush, flush beats bubble, and an empty ID slot acts as a bubble
    function automatic step_e step_sel(input logic halt, input logic flush,
                                       input logic bubble, input logic valid);
        if (halt)                  return STEP_HOLD;
        else if (flush)            return STEP_FLUSH;
        else if (bubble || !valid) return STEP_BUBBLE;
        else                       return STEP_LOAD;
    endfunction

endpackage

// File: rtl/control_pipeline_ctrl_stage_reg.sv
// One pipeline stage register: load, hold, or clear to the bubble pattern.
// Latency: 1 cycle from d to q.
// Backpressure: hold freezes contents; hold has priority over clear.
module ctrl_stage_reg #(
    parameter int         W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Async reset to bubble; otherwise hold, clear, or capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= BUBBLE;
        else if (hold)  q <= q;
        else if (clear) q <= BUBBLE;
        else            q <= d;
    end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control bits from ID through EX, MEM and WB, with bubble/flush/halt and a retire counter.
// Latency: ID/EX +1, EX/MEM +2, MEM/WB +3 cycles.
// Backpressure: i_halt freezes every stage and the counter; no ready signal is produced.
module control_pipeline
    import control_pipeline_pkg::*;
#(
    parameter int OP_ALU_BUS_SIZE = OP_ALU_BUS_SIZE_DEF,
    parameter int RETIRE_CNT_SIZE = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic                       i_halt,
    input  logic                       i_bubble,
    input  logic                       i_flush,
    input  logic                       i_wb_reg_write,
    input  logic                       i_wb_mem_to_reg,
    input  logic                       i_mem_branch,
    input  logic                       i_mem_read,
    input  logic                       i_mem_write,
    input  logic                       i_ex_dest,
    input  logic                       i_ex_alu_src,
    input  logic [OP_ALU_BUS_SIZE-1:0] i_ex_alu_op,
    output logic                       o_ex_valid,
    output logic                       o_ex_dest,
    output logic                       o_ex_alu_src,
    output logic [OP_ALU_BUS_SIZE-1:0] o_ex_alu_op,
    output logic                       o_mem_valid,
    output logic                       o_mem_branch,
    output logic                       o_mem_read,
    output logic                       o_mem_write,
    output logic                       o_wb_valid,
    output logic                       o_wb_reg_write,
    output logic                       o_wb_mem_to_reg,
    output logic [1:0]                 o_inflight,
    output logic                       o_drained,
    output logic [RETIRE_CNT_SIZE-1:0] o_retired
);

    // Stage layouts, MSB first. Each later stage is the top slice of the one before it:
    //   ID/EX : valid, reg_write, mem_to_reg, branch, read, write, dest, alu_src, alu_op
    //   EX/MEM: valid, reg_write, mem_to_reg, branch, read, write
    //   MEM/WB: valid, reg_write, mem_to_reg
    localparam int IDEX_W  = OP_ALU_BUS_SIZE + 8;
    localparam int EXMEM_W = 6;
    localparam int MEMWB_W = 3;

    localparam logic [IDEX_W-1:0]  IDEX_BUBBLE  = {8'b0, OP_ALU_BUS_SIZE'(ALU_OP_BUBBLE)};
    localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = '0;
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = '0;

    step_e               step;
    logic                hold;
    logic                idex_clr;
    logic                exmem_clr;
    logic                dest_clean;
    logic                m2r_clean;
    logic [IDEX_W-1:0]   idex_d;
    logic [IDEX_W-1:0]   idex_q;
    logic [EXMEM_W-1:0]  exmem_q;
    logic [MEMWB_W-1:0]  memwb_q;

    // Decode this edge's action into per-stage hold/clear strobes
    always_comb begin
        step      = step_sel(i_halt, i_flush, i_bubble, i_valid);
        hold      = (step == STEP_HOLD);
        idex_clr  = (step != STEP_LOAD);
        exmem_clr = (step == STEP_FLUSH);
    end

    // Fields that the decoder may leave undefined are forced to a known 0 unless clearly high
    always_comb begin
        dest_clean = LOW;
        m2r_clean  = LOW;
        if (i_ex_dest == HIGH)       dest_clean = HIGH;
        if (i_wb_mem_to_reg == HIGH) m2r_clean  = HIGH;
    end

    assign idex_d = {HIGH, i_wb_reg_write, m2r_clean, i_mem_branch, i_mem_read,
                     i_mem_write, dest_clean, i_ex_alu_src, i_ex_alu_op};

    ctrl_stage_reg #(.W(IDEX_W), .BUBBLE(IDEX_BUBBLE)) u_idex (
        .clk   (i_clk),
        .rst   (i_reset),
        .hold  (hold),
        .clear (idex_clr),
        .d     (idex_d),
        .q     (idex_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W), .BUBBLE(EXMEM_BUBBLE)) u_exmem (
        .clk   (i_clk),
        .rst   (i_reset),
        .hold  (hold),
        .clear (exmem_clr),
        .d     (idex_q[IDEX_W-1 -: EXMEM_W]),
        .q     (exmem_q)
    );

    ctrl_stage_reg #(.W(MEMWB_W), .BUBBLE(MEMWB_BUBBLE)) u_memwb (
        .clk   (i_clk),
        .rst   (i_reset),
        .hold  (hold),
        .clear (LOW),
        .d     (exmem_q[EXMEM_W-1 -: MEMWB_W]),
        .q     (memwb_q)
    );

    assign {o_ex_valid, o_ex_dest, o_ex_alu_src, o_ex_alu_op} =
           {idex_q[IDEX_W-1], idex_q[OP_ALU_BUS_SIZE+1], idex_q[OP_ALU_BUS_SIZE],
            idex_q[OP_ALU_BUS_SIZE-1:0]};
    assign {o_mem_valid, o_mem_branch, o_mem_read, o_mem_write} =
           {exmem_q[5], exmem_q[2], exmem_q[1], exmem_q[0]};
    assign {o_wb_valid, o_wb_reg_write, o_wb_mem_to_reg} = memwb_q;

    assign o_inflight = {1'b0, o_ex_valid} + {1'b0, o_mem_valid} + {1'b0, o_wb_valid};
    assign o_drained  = (o_inflight == 2'd0);

    // Count an instruction each time a valid MEM/WB entry is shifted out; wraps naturally
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                  o_retired <= '0;
        else if (!hold && o_wb_valid) o_retired <= o_retired + RETIRE_CNT_SIZE'(1);
    end

endmodule

// File: tb/tb_control_pipeline.sv
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       rst, valid, halt, bubble, flush;
    logic       rw, m2r, br, mr, mw, dest, asrc;
    logic [1:0] op;

    logic       ex_valid, ex_dest, ex_alu_src, mem_valid, mem_branch, mem_read, mem_write;
    logic       wb_valid, wb_reg_write, wb_mem_to_reg, drained;
    logic [1:0] ex_alu_op, inflight;
    logic [15:0] retired;

    logic       w_ex_valid, w_ex_dest, w_ex_alu_src, w_mem_valid, w_mem_branch, w_mem_read;
    logic       w_mem_write, w_wb_valid, w_wb_reg_write, w_wb_mem_to_reg, w_drained;
    logic [1:0] w_ex_alu_op, w_inflight, w_retired;

    logic [2:0] vld;
    assign vld = {ex_valid, mem_valid, wb_valid};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipeline dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_halt(halt), .i_bubble(bubble),
        .i_flush(flush), .i_wb_reg_write(rw), .i_wb_mem_to_reg(m2r), .i_mem_branch(br),
        .i_mem_read(mr), .i_mem_write(mw), .i_ex_dest(dest), .i_ex_alu_src(asrc),
        .i_ex_alu_op(op),
        .o_ex_valid(ex_valid), .o_ex_dest(ex_dest), .o_ex_alu_src(ex_alu_src),
        .o_ex_alu_op(ex_alu_op), .o_mem_valid(mem_valid), .o_mem_branch(mem_branch),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_wb_valid(wb_valid),
        .o_wb_reg_write(wb_reg_write), .o_wb_mem_to_reg(wb_mem_to_reg),
        .o_inflight(inflight), .o_drained(drained), .o_retired(retired)
    );

    control_pipeline #(.RETIRE_CNT_SIZE(2)) dut_w (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_halt(halt), .i_bubble(bubble),
        .i_flush(flush), .i_wb_reg_write(rw), .i_wb_mem_to_reg(m2r), .i_mem_branch(br),
        .i_mem_read(mr), .i_mem_write(mw), .i_ex_dest(dest), .i_ex_alu_src(asrc),
        .i_ex_alu_op(op),
        .o_ex_valid(w_ex_valid), .o_ex_dest(w_ex_dest), .o_ex_alu_src(w_ex_alu_src),
        .o_ex_alu_op(w_ex_alu_op), .o_mem_valid(w_mem_valid), .o_mem_branch(w_mem_branch),
        .o_mem_read(w_mem_read), .o_mem_write(w_mem_write), .o_wb_valid(w_wb_valid),
        .o_wb_reg_write(w_wb_reg_write), .o_wb_mem_to_reg(w_wb_mem_to_reg),
        .o_inflight(w_inflight), .o_drained(w_drained), .o_retired(w_retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic i_rw, input logic i_m2r, input logic i_br,
                             input logic i_mr, input logic i_mw, input logic i_dest,
                             input logic i_asrc, input logic [1:0] i_op);
        valid = v; rw = i_rw; m2r = i_m2r; br = i_br; mr = i_mr; mw = i_mw;
        dest = i_dest; asrc = i_asrc; op = i_op;
    endtask

    task automatic set_lw();     set_instr(1, 1, 0, 0, 1, 0, 0, 0, 2'b00); endtask
    task automatic set_rtype();  set_instr(1, 1, 0, 0, 0, 0, 1, 0, 2'b10); endtask
    task automatic set_beq();    set_instr(1, 0, 0, 1, 0, 0, 0, 0, 2'b01); endtask
    task automatic set_idle();   set_instr(0, 0, 0, 0, 0, 0, 0, 0, 2'b00); endtask

    task automatic do_reset();
        halt = 0; bubble = 0; flush = 0; set_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        halt = 0; bubble = 0; flush = 0;
        set_instr(1, 1, 1, 1, 1, 1, 1, 1, 2'b11);
        rst = 1;
        tick(); tick();
        checks++; if (vld !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", vld); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL reset_drained: got %b want 1", drained); end
        checks++; if ({ex_alu_op, ex_dest, wb_reg_write} !== 4'b0) begin errors++;
            $display("FAIL reset_fields: got %b want 0000", {ex_alu_op, ex_dest, wb_reg_write}); end
        rst = 0;
        set_idle();
    endtask

    task automatic test_straight();
        do_reset();
        set_lw();
        tick();
        checks++; if (vld !== 3'b100) begin errors++; $display("FAIL straight_p1: got %b want 100", vld); end
        set_idle();
        tick();
        checks++; if ({mem_valid, mem_read} !== 2'b11) begin errors++;
            $display("FAIL straight_p2_read: got %b want 11", {mem_valid, mem_read}); end
        tick();
        checks++; if ({wb_valid, wb_reg_write, wb_mem_to_reg} !== 3'b110) begin errors++;
            $display("FAIL straight_p3_wb: got %b want 110", {wb_valid, wb_reg_write, wb_mem_to_reg}); end
        tick();
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL straight_p4_retired: got %0d want 1", retired); end
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL straight_p4_drained: got %b want 1", drained); end
    endtask

    task automatic test_flush();
        do_reset();
        set_rtype(); tick();
        set_beq();   tick();
        set_idle();  tick();
        checks++; if ({vld, mem_branch, wb_reg_write} !== 5'b01111) begin errors++;
            $display("FAIL flush_pre: got %b want 01111", {vld, mem_branch, wb_reg_write}); end
        set_rtype(); flush = 1;
        tick();
        checks++; if (vld !== 3'b001) begin errors++; $display("FAIL flush_valid: got %b want 001", vld); end
        checks++; if ({mem_branch, ex_alu_op, ex_dest, wb_reg_write} !== 5'b0) begin errors++;
            $display("FAIL flush_fields: got %b want 00000", {mem_branch, ex_alu_op, ex_dest, wb_reg_write}); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL flush_retired: got %0d want 1", retired); end
        flush = 0; set_idle();
        tick();
        checks++; if ({retired, inflight} !== {16'd2, 2'd0}) begin errors++;
            $display("FAIL flush_drain: got retired %0d inflight %0d want 2 0", retired, inflight); end
    endtask

    task automatic test_bubble_halt();
        do_reset();
        set_rtype(); tick();
        set_lw(); bubble = 1; tick();
        checks++; if (vld !== 3'b010) begin errors++; $display("FAIL bubble_slot: got %b want 010", vld); end
        bubble = 0; tick();
        checks++; if ({vld, inflight} !== 5'b10110) begin errors++;
            $display("FAIL bubble_gap: got %b want 10110", {vld, inflight}); end
        set_instr(1, 0, 1, 1, 0, 1, 1, 1, 2'b11); halt = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({vld, ex_alu_op, ex_dest, ex_alu_src, wb_reg_write, mem_write} !== 9'b101000010) begin errors++;
                $display("FAIL halt_hold_%0d: got %b want 101000010", i,
                         {vld, ex_alu_op, ex_dest, ex_alu_src, wb_reg_write, mem_write}); end
            checks++; if ({inflight, retired} !== {2'd2, 16'd0}) begin errors++;
                $display("FAIL halt_count_%0d: got inflight %0d retired %0d want 2 0", i, inflight, retired); end
        end
        halt = 0; set_idle();
        tick();
        checks++; if ({vld, mem_read, retired} !== {3'b010, 1'b1, 16'd1}) begin errors++;
            $display("FAIL halt_resume: got %b %b %0d want 010 1 1", vld, mem_read, retired); end
        tick(); tick();
        checks++; if ({retired, drained} !== {16'd2, 1'b1}) begin errors++;
            $display("FAIL halt_drain: got retired %0d drained %b want 2 1", retired, drained); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_w [5];
        exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 5) set_lw(); else set_idle();
            tick();
            if (k >= 4) begin
                checks++; if (w_retired !== exp_w[k-4]) begin errors++;
                    $display("FAIL wrap_%0d: got %0d want %0d", k - 4, w_retired, exp_w[k-4]); end
            end
        end
        checks++; if (retired !== 16'd5) begin errors++; $display("FAIL wrap_wide: got %0d want 5", retired); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lw();
        tick(); tick(); tick(); tick();
        checks++; if ({inflight, retired} !== {2'd3, 16'd1}) begin errors++;
            $display("FAIL areset_pre: got inflight %0d retired %0d want 3 1", inflight, retired); end
        #2;
        rst = 1;
        #1;
        checks++; if (vld !== 3'b000) begin errors++; $display("FAIL areset_valid: got %b want 000", vld); end
        checks++; if ({retired, drained, inflight} !== {16'd0, 1'b1, 2'd0}) begin errors++;
            $display("FAIL areset_state: got retired %0d drained %b inflight %0d want 0 1 0", retired, drained, inflight); end
        checks++; if (clk !== 1'b1) begin errors++; $display("FAIL areset_timing: clk %b want 1 (same high phase)", clk); end
        tick();
        rst = 0; set_idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_rtype(); tick();
        set_beq();   tick();
        set_lw(); flush = 1; bubble = 1;
        tick();
        checks++; if ({vld, inflight} !== 5'b00101) begin errors++;
            $display("FAIL simul_valid: got %b want 00101", {vld, inflight}); end
        checks++; if ({mem_branch, ex_dest, ex_alu_op, wb_reg_write} !== 5'b00001) begin errors++;
            $display("FAIL simul_fields: got %b want 00001", {mem_branch, ex_dest, ex_alu_op, wb_reg_write}); end
        flush = 0; bubble = 0; set_idle();
        tick();
        checks++; if ({retired, drained} !== {16'd1, 1'b1}) begin errors++;
            $display("FAIL simul_drain: got retired %0d drained %b want 1 1", retired, drained); end
    endtask

    initial begin
        rst = 1; halt = 0; bubble = 0; flush = 0;
        set_idle();
        test_reset();
        test_straight();
        test_flush();
        test_bubble_halt();
        test_wrap();
        test_async_reset();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
